sha256_round_pipe_stage: RTL and testbench

- One registered SHA-256 compression round (round index fixed by parameter).
- Sits directly downstream of the message-schedule pipeline stage and consumes one W word per transaction together with the working state a..h.
- Stages are chained 64-deep to form the fully pipelined compressor.
- Valid/ready handshake with a 2-entry skid buffer, so a downstream stall never drops data and in_ready is a pure register output.

---
 rtl/sha256_pkg.sv | 66 ++++++
 rtl/sha256_round_comb.sv | 32 +++
 rtl/sha256_round_pipe_stage.sv | 125 ++++++++++++
 tb/tb_sha256_round_pipe_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// ============================================================================
// Module      : sha256_pkg
// Description : Shared SHA-256 definitions: widths, round constants K[0..63],
//               and the Sigma/sigma/Ch/Maj helper functions used by the
//               round and message-schedule stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha256_pkg;

  localparam int unsigned STATE_W = 256;
  localparam int unsigned WORD_W  = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Sigma0 = ROTR2 ^ ROTR13 ^ ROTR22
  function automatic word_t big_sigma0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  // Sigma1 = ROTR6 ^ ROTR11 ^ ROTR25
  function automatic word_t big_sigma1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  // sigma0 = ROTR7 ^ ROTR18 ^ SHR3 (message schedule)
  function automatic word_t small_sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1 = ROTR17 ^ ROTR19 ^ SHR10 (message schedule)
  function automatic word_t small_sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage : sha256_pkg

`default_nettype wire

// File: rtl/sha256_round_comb.sv
// ============================================================================
// Module      : sha256_round_comb
// Description : Purely combinational SHA-256 compression round:
//               (state a..h, W, K) -> updated state a..h. All sums mod 2^32.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_round_comb
  import sha256_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  input  logic [WORD_W-1:0]  i_w,
  input  logic [WORD_W-1:0]  i_k,
  output logic [STATE_W-1:0] o_state
);

  word_t w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  word_t w_t1, w_t2;

  // a occupies the most significant word
  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

  // 32-bit operands keep every sum truncated, so carries out of bit 31 vanish
  assign w_t1 = w_h + big_sigma1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
  assign w_t2 = big_sigma0(w_a) + maj(w_a, w_b, w_c);

  assign o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule : sha256_round_comb

`default_nettype wire

// File: rtl/sha256_round_pipe_stage.sv
// ============================================================================
// Module      : sha256_round_pipe_stage
// Description : One registered SHA-256 round with valid/ready handshake and a
//               2-entry skid buffer (main M drives outputs, skid S behind it).
//               Optional tag sideband enabled by macro SHA256_ROUND_TAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_round_pipe_stage
  import sha256_pkg::*;
#(
  parameter int unsigned ROUND_IDX = 0,
  parameter int unsigned TAG_W     = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  input  logic [WORD_W-1:0]  w_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out
`ifdef SHA256_ROUND_TAG_EN
  ,
  input  logic [TAG_W-1:0]   tag_in,
  output logic [TAG_W-1:0]   tag_out
`endif
);

  localparam logic [5:0] c_K_IDX = ROUND_IDX[5:0];

  logic               r_mv, r_sv, r_rdy;
  logic [STATE_W-1:0] r_m_state, r_s_state;
  logic [STATE_W-1:0] w_result;
  logic               w_accept, w_drain;
  logic               w_load_m, w_load_s, w_s_to_m;

  sha256_round_comb u_round (
    .i_state (state_in),
    .i_w     (w_in),
    .i_k     (K[c_K_IDX]),
    .o_state (w_result)
  );

  assign w_accept = in_valid & r_rdy;
  assign w_drain  = r_mv & out_ready;

  // New data goes to M unless M is occupied and holding; then it parks in S.
  // S only refills M when nothing new arrives (accept implies S was empty).
  assign w_load_m = w_accept & (~r_mv | w_drain);
  assign w_load_s = w_accept & r_mv & ~w_drain;
  assign w_s_to_m = ~w_accept & w_drain & r_sv;

  assign in_ready  = r_rdy;
  assign out_valid = r_mv;
  assign state_out = r_m_state;

  // Occupancy flags; in_ready is kept as its own flop mirroring !sv
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_mv  <= 1'b0;
      r_sv  <= 1'b0;
      r_rdy <= 1'b1;
    end else if (w_load_m) begin
      r_mv <= 1'b1;
    end else if (w_load_s) begin
      r_sv  <= 1'b1;
      r_rdy <= 1'b0;
    end else if (w_s_to_m) begin
      r_sv  <= 1'b0;
      r_rdy <= 1'b1;
    end else if (w_drain) begin
      r_mv <= 1'b0;
    end
  end

  // Round results land in M or S; S shifts forward into M as M drains
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_m_state <= '0;
      r_s_state <= '0;
    end else begin
      if (w_load_m) begin
        r_m_state <= w_result;
      end else if (w_s_to_m) begin
        r_m_state <= r_s_state;
      end
      if (w_load_s) begin
        r_s_state <= w_result;
      end
    end
  end

`ifdef SHA256_ROUND_TAG_EN
  logic [TAG_W-1:0] r_m_tag, r_s_tag;

  assign tag_out = r_m_tag;

  // Tag follows its data through the same M/S path
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_m_tag <= '0;
      r_s_tag <= '0;
    end else begin
      if (w_load_m) begin
        r_m_tag <= tag_in;
      end else if (w_s_to_m) begin
        r_m_tag <= r_s_tag;
      end
      if (w_load_s) begin
        r_s_tag <= tag_in;
      end
    end
  end
`else
  // Without tags the width parameter has no storage; keep it referenced
  if (TAG_W == 0) begin : g_no_tag_width
  end
`endif

endmodule : sha256_round_pipe_stage

`default_nettype wire

// File: tb/tb_sha256_round_pipe_stage.sv
// ============================================================================
// Module      : tb_sha256_round_pipe_stage
// Description : Directed self-checking bench for sha256_round_pipe_stage.
//               Covers the tag sideband when SHA256_ROUND_TAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha256_round_pipe_stage;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;

  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic [255:0] state_in = '0, state_out;
  logic [31:0]  w_in = '0;

  logic         in_valid63 = 1'b0;
  logic         in_ready63, out_valid63;
  logic [255:0] state_in63 = '0, state_out63;
  logic [31:0]  w_in63 = '0;

`ifdef SHA256_ROUND_TAG_EN
  logic [31:0]  tag_in = '0, tag_out;
  logic [31:0]  tag_in63 = '0, tag_out63;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  sha256_round_pipe_stage #(.ROUND_IDX(0), .TAG_W(32)) u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .w_in      (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
`ifdef SHA256_ROUND_TAG_EN
    ,
    .tag_in    (tag_in),
    .tag_out   (tag_out)
`endif
  );

  sha256_round_pipe_stage #(.ROUND_IDX(63), .TAG_W(32)) u_dut63 (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid63),
    .in_ready  (in_ready63),
    .state_in  (state_in63),
    .w_in      (w_in63),
    .out_valid (out_valid63),
    .out_ready (1'b1),
    .state_out (state_out63)
`ifdef SHA256_ROUND_TAG_EN
    ,
    .tag_in    (tag_in63),
    .tag_out   (tag_out63)
`endif
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Round 0 on an all-zero state: T1 = K[0] + W, T2 = 0, so a' = e' = 428a2f98 + W
  function automatic logic [255:0] zero_state_result(input logic [31:0] w);
    logic [31:0] t;
    t = 32'h428a2f98 + w;
    return {t, 96'h0, t, 96'h0};
  endfunction

  initial begin
    // reset state
    #12;
    check_eq("rst_out_valid", {255'h0, out_valid}, 256'h0);
    check_eq("rst_in_ready",  {255'h0, in_ready},  256'h1);
    check_eq("rst_state_out", state_out, 256'h0);
    RST = 1'b1;
    @(negedge CLK);

    // "abc" block, round 0
    in_valid  = 1'b1;
    out_ready = 1'b1;
    state_in  = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    w_in      = 32'h61626380;
    @(negedge CLK);
    in_valid = 1'b0;
    check_eq("abc_valid", {255'h0, out_valid}, 256'h1);
    check_eq("abc_state", state_out,
             {32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
              32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab});
    @(negedge CLK);
    check_eq("abc_drained", {255'h0, out_valid}, 256'h0);

    // back-to-back streaming of 8 items
    state_in = '0;
    for (int i = 0; i < 8; i++) begin
      check_eq("stream_in_ready", {255'h0, in_ready}, 256'h1);
      in_valid = 1'b1;
      w_in     = 32'(i + 1);
      @(negedge CLK);
      check_eq("stream_valid", {255'h0, out_valid}, 256'h1);
      check_eq("stream_state", state_out, zero_state_result(32'(i + 1)));
    end
    in_valid = 1'b0;
    @(negedge CLK);
    check_eq("stream_empty", {255'h0, out_valid}, 256'h0);

    // stall and skid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    w_in      = 32'h100;
    @(negedge CLK);
    check_eq("stall_rdy1", {255'h0, in_ready}, 256'h1);
    w_in = 32'h200;
    @(negedge CLK);
    check_eq("stall_rdy_low", {255'h0, in_ready}, 256'h0);
    check_eq("stall_hold_a", state_out, zero_state_result(32'h100));
    w_in = 32'h300;
    @(negedge CLK);
    check_eq("stall_still_low", {255'h0, in_ready}, 256'h0);
    check_eq("stall_still_a", state_out, zero_state_result(32'h100));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    check_eq("skid_b_valid", {255'h0, out_valid}, 256'h1);
    check_eq("skid_b_state", state_out, zero_state_result(32'h200));
    check_eq("skid_rdy_back", {255'h0, in_ready}, 256'h1);
    @(negedge CLK);
    check_eq("skid_c_dropped", {255'h0, out_valid}, 256'h0);

    // wrap-around arithmetic at round 63 (K = c67178f2)
    in_valid63 = 1'b1;
    state_in63 = {32'h0, 32'h0, 32'h0, 32'h00000011,
                  32'hffffffff, 32'h0, 32'h0, 32'hffffffff};
    w_in63     = 32'hffffffff;
    @(negedge CLK);
    in_valid63 = 1'b0;
    check_eq("wrap_valid", {255'h0, out_valid63}, 256'h1);
    check_eq("wrap_state", state_out63,
             {32'hc67178ef, 32'h0, 32'h0, 32'h0,
              32'hc6717900, 32'hffffffff, 32'h0, 32'h0});

    // reset mid-flight with M and S both full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    w_in      = 32'h10;
    @(negedge CLK);
    w_in = 32'h20;
    @(negedge CLK);
    in_valid = 1'b0;
    check_eq("full_rdy_low", {255'h0, in_ready}, 256'h0);
    #2 RST = 1'b0;
    #1;
    check_eq("arst_valid", {255'h0, out_valid}, 256'h0);
    check_eq("arst_ready", {255'h0, in_ready},  256'h1);
    check_eq("arst_state", state_out, 256'h0);
    #1 RST = 1'b1;
    @(negedge CLK);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    w_in      = 32'h30;
    @(negedge CLK);
    in_valid = 1'b0;
    check_eq("post_rst_valid", {255'h0, out_valid}, 256'h1);
    check_eq("post_rst_state", state_out, zero_state_result(32'h30));
    @(negedge CLK);
    check_eq("post_rst_empty", {255'h0, out_valid}, 256'h0);

`ifdef SHA256_ROUND_TAG_EN
    // tags 1,2,3 under random downstream stalls
    begin
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      while (got < 3 && cyc < 200) begin
        @(negedge CLK);
        cyc++;
        in_valid  = (sent < 3);
        w_in      = 32'h40 + 32'(sent + 1);
        tag_in    = 32'(sent + 1);
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          check_eq("tag_seq", {224'h0, tag_out}, 256'(got + 1));
          check_eq("tag_state", state_out, zero_state_result(32'h40 + 32'(got + 1)));
          got++;
        end
        if (in_valid && in_ready) sent++;
      end
      if (got < 3) begin
        check_eq("tag_timeout", 256'(got), 256'd3);
      end
      in_valid = 1'b0;
    end
`endif

    @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sha256_round_pipe_stage

`default_nettype wire
